// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/VESA raster timing generator.
//
// Divides the system clock down to a pixel strobe, runs horizontal and
// vertical raster counters on that strobe, and derives sync, blanking and
// start-of-line/frame indications for the downstream renderers.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   enable      in   run/pause; low freezes divider, counters and frame count
//   p_tick      out  pixel strobe, one clk wide
//   x           out  horizontal count, 0..H_TOTAL-1
//   y           out  vertical count, 0..V_TOTAL-1
//   hsync       out  registered horizontal sync, active level HSYNC_POL
//   vsync       out  registered vertical sync, active level VSYNC_POL
//   video_on    out  high inside the visible area
//   line_start  out  strobe on the first pixel of each line
//   frame_start out  strobe on the first pixel of each frame
//   frame_count out  completed-frame counter, wraps modulo 2^FCW
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 10,
    parameter int unsigned FCW       = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    output logic           p_tick,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // A one-bit divider is kept even for CLK_DIV=1; it then simply stays at 0.
    localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0]  div_q, div_d;
    logic [CW-1:0]  x_q, x_d;
    logic [CW-1:0]  y_q, y_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           hsync_q, vsync_q;

    logic tick;
    logic line_end;
    logic frame_end;
    logic in_hsync;
    logic in_vsync;

    assign tick      = enable && (div_q == '0);
    assign line_end  = (x_q == H_LAST);
    assign frame_end = line_end && (y_q == V_LAST);
    assign in_hsync  = (x_q >= HS_START) && (x_q <= HS_END);
    assign in_vsync  = (y_q >= VS_START) && (y_q <= VS_END);

    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        fc_d  = fc_q;

        // Divider only moves while enabled so a pause keeps the pixel phase.
        if (enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end

        if (tick) begin
            x_d = line_end ? '0 : x_q + CW'(1);
            if (line_end) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end
            if (frame_end) begin
                fc_d = fc_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fc_q    <= fc_d;
            // Syncs are sampled every clk from the current counters, giving one
            // clk of latency; frozen counters therefore hold the sync level.
            hsync_q <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync_q <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign p_tick      = tick;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_count = fc_q;
    assign video_on    = (x_q < H_VIS) && (y_q < V_VIS);
    assign line_start  = tick && (x_q == '0);
    assign frame_start = tick && (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 800x525 mode, a small
// 14x7 mode with CLK_DIV=2, and the same small mode with CLK_DIV=1, FCW=2)
// are checked every clk against an arithmetic model of the raster: the
// number of enabled clk edges since reset fixes the pixel count, and x, y and
// the frame count follow from division/modulo of that count.
module tb_vga_timing_gen;

    localparam int NI = 3;
    // Per-instance mode constants (0 = default, 1 = small, 2 = small div1).
    localparam int HT  [NI] = '{800, 14, 14};
    localparam int VT  [NI] = '{525, 7, 7};
    localparam int HD  [NI] = '{640, 8, 8};
    localparam int VD  [NI] = '{480, 4, 4};
    localparam int HS0 [NI] = '{656, 10, 10};
    localparam int HS1 [NI] = '{751, 11, 11};
    localparam int VS0 [NI] = '{490, 5, 5};
    localparam int VS1 [NI] = '{491, 5, 5};
    localparam int DV  [NI] = '{4, 2, 1};
    localparam int FM  [NI] = '{256, 256, 4};
    localparam bit HP  [NI] = '{1'b0, 1'b1, 1'b1};
    localparam bit VP  [NI] = '{1'b0, 1'b0, 1'b0};

    logic       clk;
    logic       reset;
    logic       en     [NI];
    logic       p_o    [NI];
    logic [9:0] x_o    [NI];
    logic [9:0] y_o    [NI];
    logic       hs_o   [NI];
    logic       vs_o   [NI];
    logic       vo_o   [NI];
    logic       ls_o   [NI];
    logic       fs_o   [NI];
    logic [7:0] fc_o   [NI];
    logic [7:0] fc_def;
    logic [7:0] fc_sm;
    logic [1:0] fc_d1;

    assign fc_o[0] = fc_def;
    assign fc_o[1] = fc_sm;
    assign fc_o[2] = {6'b0, fc_d1};

    int n_cmp;
    int n_fail;

    // Model state: enabled edges since reset and the sync levels expected now.
    int e      [NI];
    bit hs_exp [NI];
    bit vs_exp [NI];

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .enable(en[0]), .p_tick(p_o[0]), .x(x_o[0]), .y(y_o[0]),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .video_on(vo_o[0]), .line_start(ls_o[0]),
        .frame_start(fs_o[0]), .frame_count(fc_def)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(10), .FCW(8)
    ) u_sm (
        .clk(clk), .reset(reset), .enable(en[1]), .p_tick(p_o[1]), .x(x_o[1]), .y(y_o[1]),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .video_on(vo_o[1]), .line_start(ls_o[1]),
        .frame_start(fs_o[1]), .frame_count(fc_sm)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(10), .FCW(2)
    ) u_d1 (
        .clk(clk), .reset(reset), .enable(en[2]), .p_tick(p_o[2]), .x(x_o[2]), .y(y_o[2]),
        .hsync(hs_o[2]), .vsync(vs_o[2]), .video_on(vo_o[2]), .line_start(ls_o[2]),
        .frame_start(fs_o[2]), .frame_count(fc_d1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pix(input int edges, input int div);
        // Pixels advanced after 'edges' enabled clks: one per CLK_DIV, first at once.
        return (edges + div - 1) / div;
    endfunction

    task automatic init_model();
        for (int i = 0; i < NI; i++) begin
            e[i]      = 0;
            hs_exp[i] = !HP[i];
            vs_exp[i] = !VP[i];
        end
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NI; i++) en[i] = 1'b0;
        #2 reset = 1'b1;
        #1;
        @(posedge clk);
        #2 reset = 1'b0;
        init_model();
    endtask

    // One clk: drive enables, compare every output with the model, take the edge.
    task automatic step(input logic [2:0] ens);
        int  n, ex, ey, ef;
        bit  ep;
        for (int i = 0; i < NI; i++) en[i] = ens[i];
        #1;
        for (int i = 0; i < NI; i++) begin
            n  = pix(e[i], DV[i]);
            ex = n % HT[i];
            ey = (n / HT[i]) % VT[i];
            ef = (n / (HT[i] * VT[i])) % FM[i];
            ep = ens[i] && (e[i] % DV[i] == 0);
            n_cmp += 10;
            if (x_o[i] !== ex[9:0]) begin
                n_fail++; $display("FAIL x inst%0d t=%0t got %0d want %0d", i, $time, x_o[i], ex);
            end
            if (y_o[i] !== ey[9:0]) begin
                n_fail++; $display("FAIL y inst%0d t=%0t got %0d want %0d", i, $time, y_o[i], ey);
            end
            if (fc_o[i] !== ef[7:0]) begin
                n_fail++;
                $display("FAIL frame_count inst%0d t=%0t got %0d want %0d", i, $time, fc_o[i], ef);
            end
            if (p_o[i] !== ep) begin
                n_fail++; $display("FAIL p_tick inst%0d t=%0t got %b want %b", i, $time, p_o[i], ep);
            end
            if (ls_o[i] !== (ep && ex == 0)) begin
                n_fail++;
                $display("FAIL line_start inst%0d t=%0t got %b want %b", i, $time, ls_o[i],
                         ep && ex == 0);
            end
            if (fs_o[i] !== (ep && ex == 0 && ey == 0)) begin
                n_fail++;
                $display("FAIL frame_start inst%0d t=%0t got %b want %b", i, $time, fs_o[i],
                         ep && ex == 0 && ey == 0);
            end
            if (vo_o[i] !== (ex < HD[i] && ey < VD[i])) begin
                n_fail++;
                $display("FAIL video_on inst%0d t=%0t got %b want %b", i, $time, vo_o[i],
                         ex < HD[i] && ey < VD[i]);
            end
            if (hs_o[i] !== hs_exp[i]) begin
                n_fail++;
                $display("FAIL hsync inst%0d t=%0t got %b want %b", i, $time, hs_o[i], hs_exp[i]);
            end
            if (vs_o[i] !== vs_exp[i]) begin
                n_fail++;
                $display("FAIL vsync inst%0d t=%0t got %b want %b", i, $time, vs_o[i], vs_exp[i]);
            end
            if (^{x_o[i], y_o[i]} === 1'bx) begin
                n_fail++; $display("FAIL xy_known inst%0d got x=%0d y=%0d want known", i,
                                   x_o[i], y_o[i]);
            end
            // Sync after this edge reflects the counters present before it.
            hs_exp[i] = (ex >= HS0[i] && ex <= HS1[i]) ? HP[i] : !HP[i];
            vs_exp[i] = (ey >= VS0[i] && ey <= VS1[i]) ? VP[i] : !VP[i];
            if (ens[i]) e[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 2700; k++) step(3'b111);
        // Mid-line, with the default hsync active: reset must clear at once.
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_cmp += 5;
            if (x_o[i] !== 10'd0) begin
                n_fail++; $display("FAIL rst_x inst%0d got %0d want 0", i, x_o[i]);
            end
            if (y_o[i] !== 10'd0) begin
                n_fail++; $display("FAIL rst_y inst%0d got %0d want 0", i, y_o[i]);
            end
            if (fc_o[i] !== 8'd0) begin
                n_fail++; $display("FAIL rst_fc inst%0d got %0d want 0", i, fc_o[i]);
            end
            if (hs_o[i] !== !HP[i]) begin
                n_fail++; $display("FAIL rst_hsync inst%0d got %b want %b", i, hs_o[i], !HP[i]);
            end
            if (vs_o[i] !== !VP[i]) begin
                n_fail++; $display("FAIL rst_vsync inst%0d got %b want %b", i, vs_o[i], !VP[i]);
            end
        end
        @(posedge clk);
        #2 reset = 1'b0;
        init_model();
        for (int i = 0; i < NI; i++) en[i] = 1'b1;
        #1;
        n_cmp += 3;
        if (p_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL first_p_tick got %b want 1", p_o[0]);
        end
        if (fs_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL first_frame_start got %b want 1", fs_o[0]);
        end
        if (ls_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL first_line_start got %b want 1", ls_o[0]);
        end
        for (int k = 0; k < 8; k++) step(3'b111);
    endtask

    task automatic test_default_line();
        int p_cnt, low_cnt, first_low, ls_k, ls_y;
        p_cnt = 0; low_cnt = 0; first_low = 0; ls_k = 0; ls_y = 0;
        apply_reset();
        for (int k = 1; k <= 3300; k++) begin
            step(3'b001);
            if (p_o[0] === 1'b1) p_cnt++;
            if (hs_o[0] === 1'b0) begin
                low_cnt++;
                if (first_low == 0) first_low = k;
            end
            if (ls_o[0] === 1'b1) begin
                ls_k = k;
                ls_y = int'(y_o[0]);
            end
        end
        n_cmp += 5;
        if (p_cnt != 825) begin
            n_fail++; $display("FAIL def_p_tick_count got %0d want 825", p_cnt);
        end
        if (low_cnt != 384) begin
            n_fail++; $display("FAIL def_hsync_low_clks got %0d want 384", low_cnt);
        end
        if (first_low != 2622) begin
            n_fail++; $display("FAIL def_hsync_first_low got %0d want 2622", first_low);
        end
        if (ls_k != 3200) begin
            n_fail++; $display("FAIL def_line_period got %0d want 3200", ls_k);
        end
        if (ls_y != 1) begin
            n_fail++; $display("FAIL def_second_line_y got %0d want 1", ls_y);
        end
    endtask

    task automatic test_small_frame();
        int v_cnt, h_cnt, max_x, max_y, prev_x;
        v_cnt = 0; h_cnt = 0; max_x = 0; max_y = 0; prev_x = 0;
        apply_reset();
        for (int k = 1; k <= 3 * 98 * 2; k++) begin
            step(3'b010);
            if (p_o[1] === 1'b1 && vo_o[1] === 1'b1) v_cnt++;
            if (hs_o[1] === 1'b1) h_cnt++;
            if (int'(x_o[1]) > max_x) max_x = int'(x_o[1]);
            if (int'(y_o[1]) > max_y) max_y = int'(y_o[1]);
            if (int'(x_o[1]) != prev_x) begin
                n_cmp++;
                if (int'(x_o[1]) != ((prev_x == 13) ? 0 : prev_x + 1)) begin
                    n_fail++; $display("FAIL sm_x_sequence got %0d want %0d", x_o[1],
                                       (prev_x == 13) ? 0 : prev_x + 1);
                end
                prev_x = int'(x_o[1]);
            end
        end
        n_cmp += 5;
        if (fc_o[1] !== 8'd3) begin
            n_fail++; $display("FAIL sm_frame_count got %0d want 3", fc_o[1]);
        end
        if (v_cnt != 96) begin
            n_fail++; $display("FAIL sm_video_ticks got %0d want 96", v_cnt);
        end
        if (h_cnt != 84) begin
            n_fail++; $display("FAIL sm_hsync_high_clks got %0d want 84", h_cnt);
        end
        if (max_x != 13) begin
            n_fail++; $display("FAIL sm_max_x got %0d want 13", max_x);
        end
        if (max_y != 6) begin
            n_fail++; $display("FAIL sm_max_y got %0d want 6", max_y);
        end
    endtask

    task automatic test_pause();
        logic hs_held, vs_held;
        apply_reset();
        // 33 pixels = line 2, x 5; reached after 65 enabled clks at CLK_DIV=2.
        for (int k = 0; k < 65; k++) step(3'b010);
        n_cmp++;
        if (x_o[1] !== 10'd5 || y_o[1] !== 10'd2) begin
            n_fail++; $display("FAIL pause_entry got x=%0d y=%0d want x=5 y=2", x_o[1], y_o[1]);
        end
        hs_held = hs_o[1];
        vs_held = vs_o[1];
        for (int k = 0; k < 17; k++) begin
            step(3'b000);
            n_cmp++;
            if (x_o[1] !== 10'd5 || y_o[1] !== 10'd2 || p_o[1] !== 1'b0 || ls_o[1] !== 1'b0 ||
                fs_o[1] !== 1'b0 || hs_o[1] !== hs_held || vs_o[1] !== vs_held) begin
                n_fail++;
                $display("FAIL pause_hold got x=%0d y=%0d p=%b ls=%b fs=%b hs=%b vs=%b want 5 2 0 0 0 %b %b",
                         x_o[1], y_o[1], p_o[1], ls_o[1], fs_o[1], hs_o[1], vs_o[1],
                         hs_held, vs_held);
            end
        end
        en[1] = 1'b1;
        #1;
        n_cmp++;
        if (p_o[1] !== 1'b0) begin
            n_fail++; $display("FAIL resume_phase got p_tick=%b want 0", p_o[1]);
        end
        step(3'b010);
        n_cmp++;
        if (p_o[1] !== 1'b1 || x_o[1] !== 10'd5) begin
            n_fail++; $display("FAIL resume_tick got p=%b x=%0d want p=1 x=5", p_o[1], x_o[1]);
        end
        step(3'b010);
        n_cmp++;
        if (x_o[1] !== 10'd6) begin
            n_fail++; $display("FAIL resume_x got %0d want 6", x_o[1]);
        end
    endtask

    task automatic test_random_enable();
        apply_reset();
        for (int k = 0; k < 400; k++) step(3'($urandom));
    endtask

    task automatic test_clkdiv1_wrap();
        int last_ls, ls_cnt, fs_cnt;
        last_ls = 0; ls_cnt = 0; fs_cnt = 0;
        apply_reset();
        for (int k = 1; k <= 4 * 98; k++) begin
            step(3'b100);
            n_cmp++;
            if (p_o[2] !== 1'b1) begin
                n_fail++; $display("FAIL d1_p_tick k=%0d got %b want 1", k, p_o[2]);
            end
            if (ls_o[2] === 1'b1) begin
                if (last_ls != 0) begin
                    n_cmp++;
                    if (k - last_ls != 14) begin
                        n_fail++; $display("FAIL d1_line_period got %0d want 14", k - last_ls);
                    end
                end
                last_ls = k;
                ls_cnt++;
            end
            if (fs_o[2] === 1'b1) begin
                fs_cnt++;
                n_cmp++;
                if (x_o[2] !== 10'd0 || y_o[2] !== 10'd0) begin
                    n_fail++; $display("FAIL d1_frame_start_origin got x=%0d y=%0d want 0 0",
                                       x_o[2], y_o[2]);
                end
            end
            if (k == 3 * 98) begin
                n_cmp++;
                if (fc_o[2] !== 8'd3) begin
                    n_fail++; $display("FAIL d1_fc_before_wrap got %0d want 3", fc_o[2]);
                end
            end
        end
        n_cmp += 3;
        if (fc_o[2] !== 8'd0) begin
            n_fail++; $display("FAIL d1_fc_wrap got %0d want 0", fc_o[2]);
        end
        if (fs_cnt != 4) begin
            n_fail++; $display("FAIL d1_frame_start_count got %0d want 4", fs_cnt);
        end
        if (ls_cnt != 28) begin
            n_fail++; $display("FAIL d1_line_start_count got %0d want 28", ls_cnt);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        for (int i = 0; i < NI; i++) en[i] = 1'b0;
        init_model();
        test_reset();
        test_default_line();
        test_small_frame();
        test_pause();
        test_random_enable();
        test_clkdiv1_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync generator.
- Produces pixel-rate tick, h/v counters, configurable-polarity hsync/vsync, video_on, line/frame start strobes and a frame counter.
- Any VESA-style mode is selected by parameters.
- Sits between the board clock and all renderers (play area, heart, menu, HP bar), which consume x/y/video_on/p_tick.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=1)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CW, 10, width of x/y counters (must hold H_TOTAL-1 and V_TOTAL-1)
- FCW, 8, frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run/pause; low freezes divider and counters
- p_tick  out  1  pixel strobe, one clk wide
- x  out  CW  horizontal count, 0..H_TOTAL-1
- y  out  CW  vertical count, 0..V_TOTAL-1
- hsync  out  1  registered horizontal sync at HSYNC_POL
- vsync  out  1  registered vertical sync at VSYNC_POL
- video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY
- line_start  out  1  strobe at first pixel of each line
- frame_start  out  1  strobe at first pixel of each frame
- frame_count  out  FCW  completed-frame counter

Behaviour:
- Derived values:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK
  - HS_START = H_DISPLAY+H_FRONT; HS_END = HS_START+H_SYNC-1; VS_START/VS_END analogous.
- Reset (asynchronous, any time, including mid-line): divider=0, x=0, y=0, frame_count=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL. Operation restarts from origin on the first clk edge after deassertion.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps, advancing only when enable=1.
  - p_tick = enable && div_cnt==0, combinational from the register.
  - CLK_DIV=1: p_tick equals enable every cycle.
- Counters, updated on the clk edge where p_tick=1:
  - x = (x==H_TOTAL-1) ? 0 : x+1.
  - y advances only when x==H_TOTAL-1, wrapping at V_TOTAL-1.
  - frame_count increments, modulo 2^FCW, when x==H_TOTAL-1 && y==V_TOTAL-1.
- Sync outputs:
  - hsync_reg <= (x in [HS_START,HS_END]) ? HSYNC_POL : ~HSYNC_POL, updated every clk. This gives one clk of latency relative to x; vsync is the same using y.
  - While enable=0, x/y hold, so the syncs hold their level.
- Combinational decodes from current counters:
  - video_on = x<H_DISPLAY && y<V_DISPLAY.
  - line_start = p_tick && x==0.
  - frame_start = p_tick && x==0 && y==0. The first enabled cycle after reset asserts frame_start and line_start.
- enable low mid-operation: no tick, counters and frame_count frozen, divider phase preserved. Resuming continues from the exact phase.
- Simultaneous x and y wrap: both go to 0 on the same edge, and frame_count increments on that edge.
- Defaults reproduce 800x525 at 25 MHz from a 100 MHz clk.

Test Plan:
- Reset: assert reset mid-frame with defaults -> immediately x=0, y=0, frame_count=0, hsync=1, vsync=1. After release with enable=1, frame_start=1 and p_tick=1 on the first cycle.
- Defaults, enable=1:
  - p_tick period 4 clk; hsync low for exactly 384 clk, starting 1 clk after x becomes 656.
  - Line period 3200 clk; vsync low for 6400 clk when y is 490..491.
- Small mode (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, HSYNC_POL=1):
  - x wraps 13->0, y wraps 6->0.
  - hsync high exactly while delayed x is 10..11.
  - video_on high for 32 ticks per frame.
  - frame_count=3 after 3*98 ticks.
- CLK_DIV=1: p_tick constant 1; x increments every clk; line_start every 14 clk in the small mode.
- Pause: deassert enable at x=5, y=2 for 17 clk -> x, y, div_cnt and syncs unchanged, no strobes. Resume -> next tick x=6 at the same divider phase.
- Frame counter wrap with FCW=2 in the small mode: after 4 frames frame_count=0. frame_start pulses once per 98 ticks, coinciding with x=0, y=0.
